// File: rtl/rv32i_top_level.sv
// Single-cycle RV32I-subset CPU: PC, instruction ROM, 32x32 register file, ALU and data RAM.
// Optional feature macro: TOP_LEVEL_JUMP_EN (adds JAL/JALR; otherwise they decode as NOPs).

module rv32i_imem #(
  parameter int unsigned DEPTH = 64
) (
  input  logic [29:0] word_addr,
  output logic [31:0] instr
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] rom [0:DEPTH-1] = '{
    0: 32'h0000_2083,
    1: 32'h0040_2103,
    2: 32'h0020_81B3,
    3: 32'h0030_2423,
    4: 32'h0000_0063,
    default: 32'h0000_0013
  };

  logic [AW-1:0] idx;

  assign idx   = AW'(word_addr % 30'(DEPTH));
  assign instr = rom[idx];
endmodule

module rv32i_dmem #(
  parameter int unsigned DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [29:0] word_addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Power-up contents only; reset deliberately leaves the array untouched.
  logic [31:0] mem [0:DEPTH-1] = '{0: 32'd5, 1: 32'd7, default: '0};

  logic [AW-1:0] idx;

  assign idx   = AW'(word_addr % 30'(DEPTH));
  assign rdata = mem[idx];

  always_ff @(posedge clk) begin
    if (rst_n && we) mem[idx] <= wdata;
  end
endmodule

module rv32i_datapath #(
  parameter int unsigned IMEM_WORDS = 64,
  parameter int unsigned DMEM_WORDS = 64
) (
  input logic clk,
  input logic rst_n
);
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef TOP_LEVEL_JUMP_EN
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
`endif

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] rf_q [0:31];
  logic [31:0] instr;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u;
  logic [31:0] rs1_val, rs2_val, alu_b, alu_y;
  logic [31:0] mem_addr, dmem_rdata;
  logic [31:0] rf_wd;
  logic        rf_we, dmem_we, alu_ok, is_r;
  logic        unused_addr_bits;
  alu_op_e     alu_op;

  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return a + b;
    endcase
  endfunction

  rv32i_imem #(.DEPTH(IMEM_WORDS)) instr_memory (
    .word_addr (pc_q[31:2]),
    .instr     (instr)
  );

  rv32i_dmem #(.DEPTH(DMEM_WORDS)) data_memory (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (dmem_we),
    .word_addr (mem_addr[31:2]),
    .wdata     (rs2_val),
    .rdata     (dmem_rdata)
  );

  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign funct7   = instr[31:25];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u    = {instr[31:12], 12'b0};
  assign rs1_val  = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? '0 : rf_q[rs2];
  assign is_r     = (opcode == OP_R);
  assign alu_b    = is_r ? rs2_val : imm_i;
  assign alu_y    = alu(alu_op, rs1_val, alu_b);
  assign mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign pc_plus4 = pc_q + 32'd4;
  assign unused_addr_bits = ^mem_addr[1:0];

  // Shared R/I decode: funct7 only qualifies R-type ops and the shift-immediates.
  always_comb begin
    alu_op = ALU_ADD;
    alu_ok = 1'b0;
    case (funct3)
      3'b000: begin
        alu_op = (is_r && funct7[5]) ? ALU_SUB : ALU_ADD;
        alu_ok = !is_r || funct7 == 7'b0000000 || funct7 == 7'b0100000;
      end
      3'b001: begin alu_op = ALU_SLL;  alu_ok = (funct7 == 7'b0000000); end
      3'b010: begin alu_op = ALU_SLT;  alu_ok = !is_r || funct7 == 7'b0000000; end
      3'b011: begin alu_op = ALU_SLTU; alu_ok = !is_r || funct7 == 7'b0000000; end
      3'b100: begin alu_op = ALU_XOR;  alu_ok = !is_r || funct7 == 7'b0000000; end
      3'b101: begin
        alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
        alu_ok = funct7 == 7'b0000000 || funct7 == 7'b0100000;
      end
      3'b110: begin alu_op = ALU_OR;   alu_ok = !is_r || funct7 == 7'b0000000; end
      default: begin alu_op = ALU_AND; alu_ok = !is_r || funct7 == 7'b0000000; end
    endcase
  end

  always_comb begin
    pc_d    = pc_plus4;
    rf_we   = 1'b0;
    rf_wd   = alu_y;
    dmem_we = 1'b0;
    case (opcode)
      OP_R, OP_IMM: rf_we = alu_ok;
      OP_LUI: begin
        rf_we = 1'b1;
        rf_wd = imm_u;
      end
      OP_LOAD: begin
        rf_we = (funct3 == 3'b010);
        rf_wd = dmem_rdata;
      end
      OP_STORE: dmem_we = (funct3 == 3'b010);
      OP_BRANCH: begin
        if ((funct3 == 3'b000 && rs1_val == rs2_val) ||
            (funct3 == 3'b001 && rs1_val != rs2_val))
          pc_d = pc_q + imm_b;
      end
`ifdef TOP_LEVEL_JUMP_EN
      OP_JAL: begin
        rf_we = 1'b1;
        rf_wd = pc_plus4;
        pc_d  = pc_q + {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          rf_we = 1'b1;
          rf_wd = pc_plus4;
          pc_d  = (rs1_val + imm_i) & ~32'd1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (rf_we && rd != 5'd0) rf_q[rd] <= rf_wd;
    end
  end
endmodule

module rv32i_top_level #(
  parameter int unsigned IMEM_WORDS = 64,
  parameter int unsigned DMEM_WORDS = 64
) (
  input logic clk,
  input logic reset
);
  rv32i_datapath #(
    .IMEM_WORDS (IMEM_WORDS),
    .DMEM_WORDS (DMEM_WORDS)
  ) datapath (
    .clk   (clk),
    .rst_n (reset)
  );
endmodule

// File: tb/tb_rv32i_top_level.sv
// Directed bench for rv32i_top_level: default program, branch loop, async reset,
// ALU/branch program, memory wrap with x0, and JAL/JALR (TOP_LEVEL_JUMP_EN aware).

module tb_rv32i_top_level;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  rv32i_top_level #(
    .IMEM_WORDS (64),
    .DMEM_WORDS (64)
  ) dut (
    .clk   (clk),
    .reset (reset)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic load_prog(input logic [31:0] prog [$]);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 64; i++)
      dut.datapath.instr_memory.rom[i] = (i < prog.size()) ? prog[i] : 32'h0000_0013;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  logic [31:0] prog [$];

  initial begin
    // Default program
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pc",   dut.datapath.pc_q, 32'h0);
    check("rst_x1",   dut.datapath.rf_q[1], 32'h0);
    check("rst_mem0", dut.datapath.data_memory.mem[0], 32'h5);
    check("rst_mem1", dut.datapath.data_memory.mem[1], 32'h7);
    check("rst_mem2", dut.datapath.data_memory.mem[2], 32'h0);
    reset = 1'b1;
    @(negedge clk); check("e1_x1", dut.datapath.rf_q[1], 32'd5);
    @(negedge clk); check("e2_x2", dut.datapath.rf_q[2], 32'd7);
    @(negedge clk); check("e3_x3", dut.datapath.rf_q[3], 32'd12);
    @(negedge clk);
    check("e4_mem2", dut.datapath.data_memory.mem[2], 32'd12);
    check("e4_pc",   dut.datapath.pc_q, 32'h10);
    repeat (8) @(negedge clk);
    check("c12_pc",   dut.datapath.pc_q, 32'h10);
    check("c12_mem0", dut.datapath.data_memory.mem[0], 32'h5);
    check("c12_mem1", dut.datapath.data_memory.mem[1], 32'h7);
    check("c12_mem2", dut.datapath.data_memory.mem[2], 32'hC);

    // Branch self-loop holds
    repeat (20) @(negedge clk);
    check("loop_pc",   dut.datapath.pc_q, 32'h10);
    check("loop_mem2", dut.datapath.data_memory.mem[2], 32'hC);
    check("loop_x1",   dut.datapath.rf_q[1], 32'd5);
    check("loop_x2",   dut.datapath.rf_q[2], 32'd7);
    check("loop_x3",   dut.datapath.rf_q[3], 32'd12);

    // Async reset between edges
    #2 reset = 1'b0;
    #1;
    check("async_pc",   dut.datapath.pc_q, 32'h0);
    check("async_x3",   dut.datapath.rf_q[3], 32'h0);
    check("async_mem2", dut.datapath.data_memory.mem[2], 32'hC);
    @(negedge clk);
    check("rstlow_pc", dut.datapath.pc_q, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("rerun_x3",   dut.datapath.rf_q[3], 32'd12);
    check("rerun_mem2", dut.datapath.data_memory.mem[2], 32'hC);
    check("rerun_pc",   dut.datapath.pc_q, 32'h10);

    // ALU, branch and funct3-qualified load program
    prog = '{32'hFFD0_0093,  // addi x1,x0,-3
             32'h0050_0113,  // addi x2,x0,5
             32'h4020_81B3,  // sub  x3,x1,x2
             32'h0020_A233,  // slt  x4,x1,x2
             32'h0020_B2B3,  // sltu x5,x1,x2
             32'h4010_D313,  // srai x6,x1,1
             32'h0020_C3B3,  // xor  x7,x1,x2
             32'h1234_5437,  // lui  x8,0x12345
             32'h01C0_D493,  // srli x9,x1,28
             32'h0011_1533,  // sll  x10,x2,x1
             32'h0020_9463,  // bne  x1,x2,+8
             32'h0010_0593,  // addi x11,x0,1 (skipped)
             32'h0020_8463,  // beq  x1,x2,+8 (not taken)
             32'h0020_0613,  // addi x12,x0,2
             32'h0000_0683}; // lb x13,0(x0) -> NOP
    load_prog(prog);
    repeat (14) @(negedge clk);
    check("alu_x1_addi", dut.datapath.rf_q[1],  32'hFFFF_FFFD);
    check("alu_x3_sub",  dut.datapath.rf_q[3],  32'hFFFF_FFF8);
    check("alu_x4_slt",  dut.datapath.rf_q[4],  32'h1);
    check("alu_x5_sltu", dut.datapath.rf_q[5],  32'h0);
    check("alu_x6_srai", dut.datapath.rf_q[6],  32'hFFFF_FFFE);
    check("alu_x7_xor",  dut.datapath.rf_q[7],  32'hFFFF_FFF8);
    check("alu_x8_lui",  dut.datapath.rf_q[8],  32'h1234_5000);
    check("alu_x9_srli", dut.datapath.rf_q[9],  32'h0000_000F);
    check("alu_x10_sll", dut.datapath.rf_q[10], 32'hA000_0000);
    check("br_x11_skip", dut.datapath.rf_q[11], 32'h0);
    check("br_x12_fall", dut.datapath.rf_q[12], 32'h2);
    check("lb_x13_nop",  dut.datapath.rf_q[13], 32'h0);
    check("alu_pc",      dut.datapath.pc_q,     32'h3C);

    // Memory wrap and x0
    prog = '{32'h0330_0093,  // addi x1,x0,0x33
             32'h1010_2423,  // sw x1,264(x0) -> mem[2]
             32'h0010_2623,  // sw x1,12(x0)
             32'h0090_0013,  // addi x0,x0,9
             32'h0000_2623,  // sw x0,12(x0)
             32'h0010_0823,  // sb x1,16(x0) -> NOP
             32'h1080_2103}; // lw x2,264(x0)
    load_prog(prog);
    repeat (7) @(negedge clk);
    check("wrap_mem2",  dut.datapath.data_memory.mem[2], 32'h33);
    check("x0_store",   dut.datapath.data_memory.mem[3], 32'h0);
    check("x0_reg",     dut.datapath.rf_q[0],            32'h0);
    check("sb_nop",     dut.datapath.data_memory.mem[4], 32'h0);
    check("wrap_lw_x2", dut.datapath.rf_q[2],            32'h33);
    check("wrap_pc",    dut.datapath.pc_q,               32'h1C);

    // JAL / JALR
    prog = '{32'h0080_00EF,  // jal  x1,+8
             32'h0000_0013,
             32'h00D0_8167}; // jalr x2,13(x1)
    load_prog(prog);
    @(negedge clk);
`ifdef TOP_LEVEL_JUMP_EN
    check("jal_x1",  dut.datapath.rf_q[1], 32'h4);
    check("jal_pc",  dut.datapath.pc_q,    32'h8);
    @(negedge clk);
    check("jalr_x2", dut.datapath.rf_q[2], 32'hC);
    check("jalr_pc", dut.datapath.pc_q,    32'h10);
`else
    check("jal_x1",  dut.datapath.rf_q[1], 32'h0);
    check("jal_pc",  dut.datapath.pc_q,    32'h4);
    repeat (2) @(negedge clk);
    check("jalr_x2", dut.datapath.rf_q[2], 32'h0);
    check("jalr_pc", dut.datapath.pc_q,    32'hC);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
